shared_reg_arbiter: RTL
=======================

SHARED_REG_ARBITER -- requirements
Module: shared_reg_arbiter

Interface
REQ-001 Parameter N_REQ SHALL default to 4 and set the number of requesters.
REQ-002 Parameter DATA_W SHALL default to 8 and set the shared register width.
REQ-003 Port clk SHALL be an input, 1 bit wide, and is the single clock; all state updates on its rising edge.
REQ-004 Port reset SHALL be an input, 1 bit wide, asynchronous and active-low.
REQ-005 Port req SHALL be an input, N_REQ bits wide, with one level request per requester.
REQ-006 Port wdata SHALL be an input, N_REQ*DATA_W bits wide; slice i carries requester i's write data.
REQ-007 Port gnt SHALL be an output, N_REQ bits wide, one-hot, indicating the current owner.
REQ-008 Port ack SHALL be an output, N_REQ bits wide, one-hot, pulsing high when the owner's write completes.
REQ-009 Port q SHALL be an output, DATA_W bits wide, and is the shared register value.
REQ-010 Port q_n SHALL be an output, DATA_W bits wide, and always equals ~q.
REQ-011 Port busy SHALL be an output, 1 bit wide, high whenever the state is not IDLE.
REQ-012 Port last_id SHALL be an output, clog2(N_REQ) bits wide, holding the index of the last requester that completed a write.

Function
REQ-013 The FSM SHALL have four states: IDLE, GRANT, ACK and RELEASE, all registered.
REQ-014 In IDLE, if any req bit is set, the block SHALL pick a winner by round-robin starting at (last_id+1) mod N_REQ, latch it as owner and go to GRANT; otherwise it stays in IDLE.
REQ-015 In GRANT, gnt[owner]=1; at the next edge, if req[owner]=1, then q<=wdata[owner], last_id<=owner and the FSM goes to ACK.
REQ-016 In GRANT, if req[owner]=0 at that edge, the request is aborted: the FSM returns to IDLE and q and last_id are unchanged.
REQ-017 ACK SHALL last exactly one cycle with ack[owner]=1; it then goes to RELEASE if req[owner]=1, else to IDLE.
REQ-018 RELEASE SHALL hold until req[owner]=0 (four-phase handshake), then go to IDLE; gnt and ack are 0 in RELEASE.
REQ-019 Latency: req sampled at edge k gives gnt high in cycle k+1, q updated and ack high in cycle k+2.
REQ-020 Requests from non-owners during GRANT, ACK or RELEASE SHALL be ignored until IDLE.
REQ-021 When several requests are simultaneous, only one grant SHALL be given; gnt and ack are never multi-hot.
REQ-022 Wrap-around: after owner N_REQ-1 completes, requester 0 SHALL have the highest priority.
REQ-023 A single persistent requester SHALL be re-granted every time IDLE is reached with its req high.

Reset
REQ-024 While reset=0: state=IDLE, q=0, q_n=all ones, gnt=0, ack=0, busy=0, last_id=N_REQ-1, so requester 0 has first priority.
REQ-025 Reset asserted mid-transaction SHALL clear immediately with no partial write; the first request after release follows REQ-019 timing.

Structure
REQ-026 Shared package shared_reg_pkg SHALL hold N_REQ, DATA_W, the ID width constant and the state encoding (IDLE=0, GRANT=1, ACK=2, RELEASE=3).
REQ-027 The round-robin selection SHALL be a combinational sub-module rr_pick with inputs req and last_id, and outputs a one-hot winner and a valid flag.

Verification
REQ-028 Test 1: hold reset=0 for 30 ns -> q=8'h00, q_n=8'hFF, gnt=0, busy=0; then assert req[2] mid-reset -> no gnt until reset is released.
REQ-029 Test 2: req=4'b0010 with wdata[1]=8'hA5 at edge k -> gnt=4'b0010 in cycle k+1, q=8'hA5, q_n=8'h5A, ack=4'b0010 in cycle k+2, last_id=1.
REQ-030 Test 3: req=4'b1111 held with wdata[i]=8'h10+i -> grant order 0,1,2,3,0, and q follows 8'h10, 8'h11, 8'h12, 8'h13.
REQ-031 Test 4: req[3] dropped during GRANT -> no ack, q unchanged, busy low on the next cycle.
REQ-032 Test 5: owner holds req for 5 cycles after ack -> state stays in RELEASE, while req[0] waiting is granted only after owner release.
REQ-033 Test 6: reset pulsed low during ACK -> all outputs return to reset values asynchronously, and q does not keep the in-flight data.

Source files
------------

// File: rtl/shared_reg_pkg.sv
// Shared constants and FSM encoding for the shared-register arbiter.
package shared_reg_pkg;

    localparam int N_REQ  = 4;
    localparam int DATA_W = 8;
    localparam int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        ACK     = 2'd2,
        RELEASE = 2'd3
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: searches upward from last_id+1, wrapping,
// and returns a one-hot winner plus a valid flag.
module rr_pick
    import shared_reg_pkg::*;
#(
    parameter int N_REQ = shared_reg_pkg::N_REQ,
    parameter int ID_W  = shared_reg_pkg::ID_W
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  last_id,
    output logic [N_REQ-1:0] winner,
    output logic             valid
);

    int idx;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(last_id) + k) % N_REQ;
            if (!valid && req[idx]) begin
                winner[idx] = 1'b1;
                valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter guarding one shared register with a four-phase
// req/gnt/ack handshake per requester.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no owner; pick next requester round-robin from last_id+1
// GRANT   | gnt[owner]=1; write on next edge if owner still requests
// ACK     | one-cycle ack[owner] pulse after the write
// RELEASE | wait for owner to drop req before going idle
module shared_reg_arbiter
    import shared_reg_pkg::*;
#(
    parameter int  N_REQ  = shared_reg_pkg::N_REQ,
    parameter int  DATA_W = shared_reg_pkg::DATA_W,
    localparam int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] wdata,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        ack,
    output logic [DATA_W-1:0]       q,
    output logic [DATA_W-1:0]       q_n,
    output logic                    busy,
    output logic [ID_W-1:0]         last_id
);

    state_t            state, state_nxt;
    logic [ID_W-1:0]   owner;
    logic [ID_W-1:0]   pick_id;
    logic [N_REQ-1:0]  winner;
    logic              win_valid;
    logic              owner_req;

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_pick (
        .req     (req),
        .last_id (last_id),
        .winner  (winner),
        .valid   (win_valid)
    );

    always_comb begin
        pick_id = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (winner[i]) pick_id = ID_W'(i);
        end
    end

    assign owner_req = req[owner];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Owner is latched on the IDLE pick; q/last_id only move on a completed write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner   <= '0;
            q       <= '0;
            last_id <= ID_W'(N_REQ - 1);
        end else begin
            if (state == IDLE && win_valid) begin
                owner <= pick_id;
            end
            if (state == GRANT && owner_req) begin
                q       <= wdata[int'(owner)*DATA_W +: DATA_W];
                last_id <= owner;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_valid) state_nxt = GRANT;
            GRANT:   state_nxt = owner_req ? ACK : IDLE;
            ACK:     state_nxt = owner_req ? RELEASE : IDLE;
            RELEASE: if (!owner_req) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        gnt  = '0;
        ack  = '0;
        busy = (state != IDLE);
        case (state)
            GRANT:   gnt[owner] = 1'b1;
            ACK:     ack[owner] = 1'b1;
            default: ;
        endcase
    end

    assign q_n = ~q;

endmodule
